alu_flag_unit: RTL and testbench
================================

# alu_flag_unit

Arithmetic/logic stage directly downstream of the register file: consumes its two 8-bit read ports (O1 → A, O2 → B), executes one of 16 functions selected by FunSel, and registers the result and a 4-bit flag register {Z,C,N,O}. Single-cycle operations complete in one clock. An optional iterative 8×8 multiplier adds a multi-cycle busy/valid handshake. OutALU feeds the register-file write input I and the memory/address path.

## Interface
- No parameters; data width is fixed at 8.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- A  in  8  operand A (register-file O1).
- B  in  8  operand B (register-file O2).
- FunSel  in  4  function select (see Operation).
- InValid  in  1  request; the operation is accepted on the rising edge where InValid=1 and Busy=0.
- FlagWE  in  1  sampled with the request; 0 = flags left unchanged.
- OutALU  out  8  registered result (product low byte for MUL).
- OutHi  out  8  product high byte; 0 after every non-MUL op.
- OutValid  out  1  one-cycle pulse: OutALU/OutHi/Flags updated.
- Busy  out  1  multiply in progress.
- Flags  out  4  {Z,C,N,O}, registered.

## Operation
- Reset: OutALU=0, OutHi=0, Flags=0, OutValid=0, Busy=0, multiplier state cleared; a multiply in progress is aborted, no OutValid.
- FunSel: 0000 A; 0001 B; 0010 ~A; 0011 ~B; 0100 A+B; 0101 A+B+C; 0110 A−B; 0111 A&B; 1000 A|B; 1001 A^B; 1010 LSL A; 1011 LSR A; 1100 ASR A; 1101 CSL A (rotate left through C); 1110 CSR A (rotate right through C); 1111 MUL (unsigned).
- Arithmetic: 9-bit sum; A−B computed as A+~B+1; C = bit 8 (for subtract, C=1 means no borrow); O = signed overflow (operand signs equal, result sign differs; for subtract use signs of A and ~B).
- Flag update rules (only when FlagWE=1): Z = (result==0); N = result[7] on every op; C updated on add/sub/shift/rotate (shifted-out bit), unchanged on pass/logic; O updated on add/sub only; MUL: Z over the full 16-bit product, N = product[15], C = O = (OutHi≠0).
- C used by 0101/1101/1110 is the value in Flags before the edge.
- Multiplier: shift-add; operands latched on accept; one partial-product step per clock, 8 steps.
- InValid while Busy=1: ignored, no effect on state or outputs.
- FlagWE=0: OutALU/OutHi/OutValid behave normally, Flags hold.

## Timing
- Single-cycle op accepted at edge k: OutALU, OutHi=0, Flags valid after edge k; OutValid=1 for the cycle following edge k.
- Back-to-back single-cycle requests: accepted every clock; OutValid stays high.
- MUL accepted at edge k: Busy=1 after edge k; steps at edges k+1…k+8; after edge k+8: result and flags written, OutValid=1 for one cycle, Busy=0. Next request accepted at edge k+9 at earliest (Busy is low when sampled there).
- OutALU/OutHi hold the last result between OutValid pulses.

## Configuration
- ALU_MUL_EN defined: iterative multiplier and Busy behaviour as above.
- Not defined: FunSel 1111 executes as single-cycle pass A (OutALU=A, Z/N updated, C/O unchanged); Busy tied 0; OutHi always 0; no multiplier registers synthesised.

## Structure
- Shared package alu_pkg: FunSel encoding constants (FS_PASS_A … FS_MUL), flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0), data width constant 8.
- One sub-module: alu_mul_seq (8-step shift-add multiplier with start/done), instantiated only under ALU_MUL_EN.

## Test plan
- Reset mid-MUL (A=0xFF, B=0xFF, rst at cycle 3) → all outputs 0, no OutValid, next op accepted normally.
- ADD A=0x7F, B=0x01, FlagWE=1 → OutALU=0x80, Flags Z0 C0 N1 O1; then SUB A=0x00, B=0x01 → 0xFF, C=0 (borrow), N=1, O=0.
- ADDC with C=1, A=0xFF, B=0x00 → OutALU=0x00, Z=1, C=1; repeat with FlagWE=0 → Flags unchanged.
- CSL A=0x80 with C=0 → OutALU=0x00, C=1, Z=1; CSR A=0x01 with C=1 → 0x80, C=1, N=1.
- MUL A=0x10, B=0x20 → Busy 8 cycles, OutValid 8 cycles after accept, OutHi=0x02, OutALU=0x00, C=O=1, Z=0; InValid during Busy ignored.
- Build without ALU_MUL_EN: FunSel 1111, A=0x00 → OutALU=0x00, Z=1, OutValid next cycle, Busy never asserted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/flag stage: function codes, flag bit positions, widths.
package alu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned MSB    = DATA_W - 1;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_O = 0;

   typedef enum logic [3:0] {
      FS_PASS_A = 4'h0,
      FS_PASS_B = 4'h1,
      FS_NOT_A  = 4'h2,
      FS_NOT_B  = 4'h3,
      FS_ADD    = 4'h4,
      FS_ADDC   = 4'h5,
      FS_SUB    = 4'h6,
      FS_AND    = 4'h7,
      FS_OR     = 4'h8,
      FS_XOR    = 4'h9,
      FS_LSL    = 4'hA,
      FS_LSR    = 4'hB,
      FS_ASR    = 4'hC,
      FS_CSL    = 4'hD,
      FS_CSR    = 4'hE,
      FS_MUL    = 4'hF
   } fun_sel_e;

   typedef enum logic {StIdle, StRun} mul_state_e;

endpackage

// File: rtl/alu_flag_unit_if.sv
// Request/result bundle between the register file, the ALU stage and its consumers.
interface alu_flag_unit_if;
   logic [7:0] A;
   logic [7:0] B;
   logic [3:0] FunSel;
   logic       InValid;
   logic       FlagWE;
   logic [7:0] OutALU;
   logic [7:0] OutHi;
   logic       OutValid;
   logic       Busy;
   logic [3:0] Flags;

   modport master (
      output A, B, FunSel, InValid, FlagWE,
      input  OutALU, OutHi, OutValid, Busy, Flags
   );

   modport slave (
      input  A, B, FunSel, InValid, FlagWE,
      output OutALU, OutHi, OutValid, Busy, Flags
   );
endinterface

// File: rtl/alu_mul_seq.sv
// 8-step shift-add unsigned multiplier. done/product are combinational on the last step
// so the caller can register the result on the same edge the final step completes.
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);
   mul_state_e          state_q, state_d;
   logic [2*DATA_W-1:0] mcand_q, acc_q, acc_d;
   logic [DATA_W-1:0]   mplier_q;
   logic [2:0]          cnt_q;

   assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign busy    = (state_q == StRun);
   assign done    = busy && (cnt_q == 3'd7);
   assign product = acc_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (start) state_d = StRun;
         StRun:  if (cnt_q == 3'd7) state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && start) begin
            mcand_q  <= {{DATA_W{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
         end else if (state_q == StRun) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 3'd1;
         end
      end
   end
endmodule

// File: rtl/alu_flag_unit.sv
// ALU stage with registered result and {Z,C,N,O} flags.
// Optional feature macro: ALU_MUL_EN adds the iterative multiplier on FunSel 1111.
module alu_flag_unit
   import alu_pkg::*;
(
   input logic            clk,
   input logic            rst,
   alu_flag_unit_if.slave bus
);
   fun_sel_e          fs;
   logic [DATA_W-1:0] a, b, res;
   logic [DATA_W:0]   sum;
   logic              c_in, c_new, o_new, accept, is_mul, busy;
   logic [3:0]        flags_sc;
   logic [DATA_W-1:0] out_alu_q;
   logic [3:0]        flags_q;
   logic              out_valid_q;

   assign fs     = fun_sel_e'(bus.FunSel);
   assign a      = bus.A;
   assign b      = bus.B;
   assign c_in   = flags_q[FLAG_C];
   assign accept = bus.InValid & ~busy;

   always_comb begin
      res   = a;
      sum   = '0;
      c_new = c_in;
      o_new = flags_q[FLAG_O];
      unique case (fs)
         FS_PASS_A, FS_MUL: res = a;
         FS_PASS_B: res = b;
         FS_NOT_A:  res = ~a;
         FS_NOT_B:  res = ~b;
         FS_ADD, FS_ADDC: begin
            sum   = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, (fs == FS_ADDC) & c_in};
            res   = sum[MSB:0];
            c_new = sum[DATA_W];
            o_new = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
         end
         FS_SUB: begin
            // C=1 means no borrow
            sum   = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
            res   = sum[MSB:0];
            c_new = sum[DATA_W];
            o_new = (a[MSB] == ~b[MSB]) && (res[MSB] != a[MSB]);
         end
         FS_AND: res = a & b;
         FS_OR:  res = a | b;
         FS_XOR: res = a ^ b;
         FS_LSL: begin res = {a[MSB-1:0], 1'b0};   c_new = a[MSB]; end
         FS_LSR: begin res = {1'b0, a[MSB:1]};     c_new = a[0];   end
         FS_ASR: begin res = {a[MSB], a[MSB:1]};   c_new = a[0];   end
         FS_CSL: begin res = {a[MSB-1:0], c_in};   c_new = a[MSB]; end
         FS_CSR: begin res = {c_in, a[MSB:1]};     c_new = a[0];   end
      endcase
      flags_sc         = '0;
      flags_sc[FLAG_Z] = (res == '0);
      flags_sc[FLAG_C] = c_new;
      flags_sc[FLAG_N] = res[MSB];
      flags_sc[FLAG_O] = o_new;
   end

`ifdef ALU_MUL_EN
   logic [2*DATA_W-1:0] product;
   logic                mul_done, mul_we_q;
   logic [DATA_W-1:0]   out_hi_q;
   logic [3:0]          flags_mul;

   assign is_mul    = (fs == FS_MUL);
   assign bus.OutHi = out_hi_q;

   alu_mul_seq u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept & is_mul),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      flags_mul         = '0;
      flags_mul[FLAG_Z] = (product == '0);
      flags_mul[FLAG_C] = (product[2*DATA_W-1:DATA_W] != '0);
      flags_mul[FLAG_N] = product[2*DATA_W-1];
      flags_mul[FLAG_O] = (product[2*DATA_W-1:DATA_W] != '0);
   end

   // FlagWE is sampled with the request, so it must survive the 8 multiply steps
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  mul_we_q <= 1'b0;
      else if (accept & is_mul) mul_we_q <= bus.FlagWE;
   end
`else
   assign is_mul    = 1'b0;
   assign busy      = 1'b0;
   assign bus.OutHi = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_alu_q   <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
         out_hi_q    <= '0;
`endif
      end else begin
         out_valid_q <= 1'b0;
         if (accept && !is_mul) begin
            out_alu_q   <= res;
            out_valid_q <= 1'b1;
            if (bus.FlagWE) flags_q <= flags_sc;
`ifdef ALU_MUL_EN
            out_hi_q    <= '0;
`endif
         end
`ifdef ALU_MUL_EN
         if (mul_done) begin
            out_alu_q   <= product[DATA_W-1:0];
            out_hi_q    <= product[2*DATA_W-1:DATA_W];
            out_valid_q <= 1'b1;
            if (mul_we_q) flags_q <= flags_mul;
         end
`endif
      end
   end

   assign bus.OutALU   = out_alu_q;
   assign bus.OutValid = out_valid_q;
   assign bus.Busy     = busy;
   assign bus.Flags    = flags_q;
endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit; the multiplier section follows ALU_MUL_EN.
module tb_alu_flag_unit;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   busy_seen = 0;
   int   valid_seen;

   alu_flag_unit_if bus ();

   alu_flag_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.Busy === 1'b1) busy_seen++;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request for one edge, then sample #1 after that edge
   task automatic issue(input fun_sel_e fs, input logic [7:0] a, input logic [7:0] b,
                        input logic we);
      bus.FunSel  = fs;
      bus.A       = a;
      bus.B       = b;
      bus.FlagWE  = we;
      bus.InValid = 1'b1;
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
   endtask

   task automatic chk_res(input string tag, input logic [7:0] alu, input logic [3:0] flg);
      chk({tag, ".valid"}, {15'd0, bus.OutValid}, 16'd1);
      chk({tag, ".alu"},   {8'd0, bus.OutALU},    {8'd0, alu});
      chk({tag, ".hi"},    {8'd0, bus.OutHi},     16'd0);
      chk({tag, ".flags"}, {12'd0, bus.Flags},    {12'd0, flg});
   endtask

   initial begin
      rst         = 1'b1;
      bus.A       = '0;
      bus.B       = '0;
      bus.FunSel  = '0;
      bus.InValid = 1'b0;
      bus.FlagWE  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.alu",   {8'd0, bus.OutALU},     16'd0);
      chk("rst.hi",    {8'd0, bus.OutHi},      16'd0);
      chk("rst.flags", {12'd0, bus.Flags},     16'd0);
      chk("rst.valid", {15'd0, bus.OutValid},  16'd0);
      chk("rst.busy",  {15'd0, bus.Busy},      16'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of an operation
`ifdef ALU_MUL_EN
      issue(FS_MUL, 8'hFF, 8'hFF, 1'b1);
      chk("mrst.busy", {15'd0, bus.Busy}, 16'd1);
      repeat (2) begin @(posedge clk); #1; end
`else
      issue(FS_PASS_A, 8'hFF, 8'h00, 1'b1);
      chk("mrst.pre", {8'd0, bus.OutALU}, 16'h00FF);
`endif
      rst = 1'b1;
      #1;
      chk("mrst.alu",   {8'd0, bus.OutALU},    16'd0);
      chk("mrst.hi",    {8'd0, bus.OutHi},     16'd0);
      chk("mrst.flags", {12'd0, bus.Flags},    16'd0);
      chk("mrst.busy",  {15'd0, bus.Busy},     16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      valid_seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (bus.OutValid === 1'b1) valid_seen++;
      end
      chk("mrst.novalid", valid_seen[15:0], 16'd0);

      // Back-to-back single-cycle ops, flags {Z,C,N,O}
      issue(FS_ADD,  8'h7F, 8'h01, 1'b1); chk_res("add",   8'h80, 4'b0011);
      issue(FS_SUB,  8'h00, 8'h01, 1'b1); chk_res("sub",   8'hFF, 4'b0010);
      issue(FS_CSL,  8'h80, 8'h00, 1'b1); chk_res("csl",   8'h00, 4'b1100);
      issue(FS_CSR,  8'h01, 8'h00, 1'b1); chk_res("csr",   8'h80, 4'b0110);
      issue(FS_SUB,  8'h80, 8'h01, 1'b1); chk_res("subo",  8'h7F, 4'b0101);
      issue(FS_ADDC, 8'hFF, 8'h00, 1'b1); chk_res("addc",  8'h00, 4'b1100);
      issue(FS_ADDC, 8'h01, 8'h01, 1'b0); chk_res("addcn", 8'h03, 4'b1100);
      issue(FS_XOR,  8'hF0, 8'h0F, 1'b1); chk_res("xor",   8'hFF, 4'b0110);
      issue(FS_NOT_A, 8'hFF, 8'h00, 1'b1); chk_res("nota", 8'h00, 4'b1100);
      issue(FS_ASR,  8'h81, 8'h00, 1'b1); chk_res("asr",   8'hC0, 4'b0110);
      issue(FS_LSR,  8'h01, 8'h00, 1'b1); chk_res("lsr",   8'h00, 4'b1100);
      issue(FS_AND,  8'hF0, 8'h0F, 1'b1); chk_res("and",   8'h00, 4'b1100);
      issue(FS_PASS_B, 8'h00, 8'h5A, 1'b1); chk_res("passb", 8'h5A, 4'b0100);

      // Idle cycle: pulse ends, result holds
      @(posedge clk);
      #1;
      chk("idle.valid", {15'd0, bus.OutValid}, 16'd0);
      chk("idle.alu",   {8'd0, bus.OutALU},    16'h005A);

`ifdef ALU_MUL_EN
      issue(FS_MUL, 8'h10, 8'h20, 1'b1);
      chk("mul.busy0",  {15'd0, bus.Busy},     16'd1);
      chk("mul.valid0", {15'd0, bus.OutValid}, 16'd0);
      // Requests while busy must be ignored
      bus.FunSel  = FS_ADD;
      bus.A       = 8'h01;
      bus.B       = 8'h01;
      bus.FlagWE  = 1'b1;
      bus.InValid = 1'b1;
      for (int i = 1; i < 8; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("mul.busy%0d", i),  {15'd0, bus.Busy},     16'd1);
         chk($sformatf("mul.valid%0d", i), {15'd0, bus.OutValid}, 16'd0);
      end
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
      chk("mul.busy8",  {15'd0, bus.Busy},     16'd0);
      chk("mul.valid8", {15'd0, bus.OutValid}, 16'd1);
      chk("mul.lo",     {8'd0, bus.OutALU},    16'h0000);
      chk("mul.hi",     {8'd0, bus.OutHi},     16'h0002);
      chk("mul.flags",  {12'd0, bus.Flags},    16'b0101);
      @(posedge clk);
      #1;
      chk("mul.pulse", {15'd0, bus.OutValid}, 16'd0);
      chk("mul.hold",  {8'd0, bus.OutALU},    16'h0000);
      issue(FS_PASS_A, 8'h00, 8'h00, 1'b1);
      chk_res("postmul", 8'h00, 4'b1101);
`else
      issue(FS_MUL, 8'h00, 8'h00, 1'b1);
      chk_res("mulpass", 8'h00, 4'b1100);
      chk("mulpass.busy", {15'd0, bus.Busy}, 16'd0);
      issue(FS_MUL, 8'h9C, 8'h03, 1'b1);
      chk_res("mulpass2", 8'h9C, 4'b0110);
      chk("nobusy", busy_seen[15:0], 16'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
